serial_subtractor: RTL and testbench

//  Bit-serial subtractor: D = A - B - Bin, computed one bit per clock, LSB first, through a single full-subtractor cell.

---
 rtl/serial_sub_pkg.sv | 10 +
 rtl/serial_subtractor_if.sv | 39 +++
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
//   sub_state_t   : control FSM state encoding (IDLE, RUN, DONE)
//   WIDTH_DEFAULT : default operand/result width
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int unsigned WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle for serial_subtractor.
//   in_valid/in_ready   : operand handshake (A, B, Bin)
//   out_valid/out_ready : result handshake (D, Bout, OVF)
//   OVF exists only when SIGNED_OVF_EN is defined.
// Modports: master = producer/consumer side (testbench), slave = subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = serial_sub_pkg::WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef SIGNED_OVF_EN
  logic             OVF;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, OVF
  );
  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, OVF
  );
`else
  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout
  );
  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout
  );
`endif
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin.
//   A, B, Bin : minuend bit, subtrahend bit, borrow in
//   D, Bout   : difference bit, borrow out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin (mod 2^WIDTH), one bit per clock, LSB first,
// through a single full_subtractor cell. One operation in flight at a time.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if.slave (operand and result valid/ready handshakes)
// Config: define SIGNED_OVF_EN to add the registered signed-overflow flag OVF.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Collects the low WIDTH-1 result bits; the last bit is merged straight into d_q.
  logic [WIDTH-2:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fs_diff, fs_bout;
`ifdef SIGNED_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Bin  (borrow_q),
    .D    (fs_diff),
    .Bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
`ifdef SIGNED_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d  = RUN;
          a_sh_d   = bus.A;
          b_sh_d   = bus.B;
          borrow_d = bus.Bin;
          cnt_d    = '0;
`ifdef SIGNED_OVF_EN
          a_msb_d  = bus.A[WIDTH-1];
          b_msb_d  = bus.B[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d             = a_sh_q >> 1;
        b_sh_d             = b_sh_q >> 1;
        d_sh_d             = d_sh_q >> 1;
        d_sh_d[WIDTH-2]    = fs_diff;
        borrow_d           = fs_bout;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Final bit: publish the result; cnt holds so it never wraps.
          state_d = DONE;
          d_d     = {fs_diff, d_sh_q};
          bout_d  = fs_bout;
`ifdef SIGNED_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SIGNED_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
`ifdef SIGNED_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.D         = d_q;
  assign bus.Bout      = bout_q;
`ifdef SIGNED_OVF_EN
  assign bus.OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, reset/backpressure cases and
// randomized operations on WIDTH=8 and WIDTH=16 instances against an integer reference model.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic        bout;
    logic        ovf;
    logic [15:0] d;
  } obs_t;

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    o.ovf = 1'b0;
    if (sel == 0) begin
      o.in_ready  = bus8.in_ready;
      o.out_valid = bus8.out_valid;
      o.bout      = bus8.Bout;
      o.d         = {8'h00, bus8.D};
`ifdef SIGNED_OVF_EN
      o.ovf       = bus8.OVF;
`endif
    end else begin
      o.in_ready  = bus16.in_ready;
      o.out_valid = bus16.out_valid;
      o.bout      = bus16.Bout;
      o.d         = bus16.D;
`ifdef SIGNED_OVF_EN
      o.ovf       = bus16.OVF;
`endif
    end
    return o;
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [15:0] a,
                          input logic [15:0] b, input logic bin);
    if (sel == 0) begin
      bus8.in_valid = v;
      bus8.A        = a[7:0];
      bus8.B        = b[7:0];
      bus8.Bin      = bin;
    end else begin
      bus16.in_valid = v;
      bus16.A        = a;
      bus16.B        = b;
      bus16.Bin      = bin;
    end
  endtask

  task automatic set_ready(input int sel, input logic r);
    if (sel == 0) bus8.out_ready = r;
    else          bus16.out_ready = r;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic bout, output logic ovf);
    longint diff;
    longint mask;
    logic   am, bm;
    mask = (longint'(1) << w) - 1;
    diff = longint'(a) - longint'(b) - longint'(bin);
    d    = 16'(diff & mask);
    bout = (diff < 0);
    am   = a[w-1];
    bm   = b[w-1];
    ovf  = (am != bm) && (d[w-1] != am);
  endtask

  // One complete transaction. hold = cycles DONE is held with out_ready low before release;
  // early = out_ready already high when the result appears; noise = in_valid kept high with
  // different operands while busy.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input int hold, input logic early, input logic noise);
    int          w;
    int          lat;
    obs_t        o;
    logic [15:0] ed;
    logic        eb, eo;
    w = (sel == 0) ? 8 : 16;
    model(w, a, b, bin, ed, eb, eo);
    o = get_obs(sel);
    check("in_ready_before_accept", 32'(o.in_ready), 32'd1);
    drive_in(sel, 1'b1, a, b, bin);
    @(posedge clk); #1;
    if (noise) drive_in(sel, 1'b1, ~a, a ^ b, ~bin);
    else       drive_in(sel, 1'b0, 16'h0, 16'h0, 1'b0);
    set_ready(sel, early);
    o = get_obs(sel);
    check("in_ready_busy", 32'(o.in_ready), 32'd0);
    lat = 0;
    while (!o.out_valid && lat < w + 4) begin
      @(posedge clk); #1;
      lat++;
      o = get_obs(sel);
    end
    check("latency", 32'(lat), 32'(w));
    check("D", 32'(o.d), 32'(ed));
    check("Bout", 32'(o.bout), 32'(eb));
`ifdef SIGNED_OVF_EN
    check("OVF", 32'(o.ovf), 32'(eo));
`endif
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        o = get_obs(sel);
        check("hold_valid", 32'(o.out_valid), 32'd1);
        check("hold_D", 32'(o.d), 32'(ed));
        check("hold_in_ready", 32'(o.in_ready), 32'd0);
      end
    end
    drive_in(sel, 1'b0, 16'h0, 16'h0, 1'b0);
    set_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_ready(sel, 1'b0);
    o = get_obs(sel);
    check("release_valid", 32'(o.out_valid), 32'd0);
    check("release_in_ready", 32'(o.in_ready), 32'd1);
    check("idle_keeps_D", 32'(o.d), 32'(ed));
  endtask

  initial begin
    obs_t o;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive_in(1, 1'b0, 16'h0, 16'h0, 1'b0);
    set_ready(0, 1'b0);
    set_ready(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      o = get_obs(s);
      check("rst_in_ready", 32'(o.in_ready), 32'd1);
      check("rst_out_valid", 32'(o.out_valid), 32'd0);
      check("rst_D", 32'(o.d), 32'd0);
      check("rst_Bout", 32'(o.bout), 32'd0);
      check("rst_OVF", 32'(o.ovf), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    run_op(0, 16'h5A, 16'h23, 1'b0, 0, 1'b0, 1'b0);
    run_op(0, 16'h00, 16'h00, 1'b1, 0, 1'b1, 1'b0);
    run_op(0, 16'h10, 16'h10, 1'b0, 1, 1'b0, 1'b0);
    run_op(0, 16'h80, 16'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op(0, 16'h7F, 16'hFF, 1'b0, 0, 1'b1, 1'b0);
    o = get_obs(0);
    check("vec_7F_FF_D", 32'(o.d), 32'h80);
    check("vec_7F_FF_Bout", 32'(o.bout), 32'd1);

    // Backpressure: 5 stalled cycles with conflicting operands offered.
    run_op(0, 16'h5A, 16'h23, 1'b0, 5, 1'b0, 1'b1);
    o = get_obs(0);
    check("bp_D_0x37", 32'(o.d), 32'h37);

    // Reset during RUN aborts the operation.
    drive_in(0, 1'b1, 16'h33, 16'h11, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    o = get_obs(0);
    check("midrst_out_valid", 32'(o.out_valid), 32'd0);
    check("midrst_in_ready", 32'(o.in_ready), 32'd1);
    check("midrst_D", 32'(o.d), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      o = get_obs(0);
      check("post_rst_no_valid", 32'(o.out_valid), 32'd0);
      check("post_rst_in_ready", 32'(o.in_ready), 32'd1);
    end

    // Randomized operations with handshake gaps on both widths.
    for (int n = 0; n < 3500; n++) begin
      int          sel;
      logic [15:0] a, b;
      sel = (n < 2500) ? 0 : 1;
      a   = 16'($urandom);
      b   = 16'($urandom);
      if (sel == 0) begin
        a[15:8] = 8'h00;
        b[15:8] = 8'h00;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_op(sel, a, b, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom),
             1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
